dram_bank_controller: RTL
=========================

# dram_bank_controller

Per-bank command sequencer for the DRAM memory controller. It accepts one decoded request at a time, as row/column fields from the address parser plus a read/write flag. It then issues the ACTIVATE / READ / WRITE / PRECHARGE sequence for one bank under an open-row policy, enforcing tRCD, tRP, tRAS and tCCD. One instance exists per (bank group, bank); a downstream command-bus arbiter grants its commands.

## Interface
Parameters:
- ROW_BITS, 8, row address width
- COL_BITS, 4, column address width
- T_RCD, 3, cycles from ACT grant to earliest RD/WR; must be >= 2
- T_RP, 3, cycles from PRE grant to earliest ACT; must be >= 2
- T_RAS, 8, cycles from ACT grant to earliest PRE; must be >= 1
- T_CCD, 2, cycles from RD/WR grant to earliest next RD/WR; must be >= 1

Ports:
- clk_in  in  1  clock; all state changes on the rising edge
- rst_in  in  1  reset; asynchronous, active-high
- req_valid_in  in  1  request present
- req_ready_out  out  1  request slot empty
- req_row_in  in  ROW_BITS  request row
- req_col_in  in  COL_BITS  request column
- req_write_in  in  1  1 = write, 0 = read
- cmd_valid_out  out  1  command presented to arbiter
- cmd_out  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_row_out  out  ROW_BITS  row for ACT; 0 otherwise
- cmd_col_out  out  COL_BITS  column for RD/WR; 0 otherwise
- cmd_grant_in  in  1  arbiter accepts the presented command this cycle
- done_out  out  1  one-cycle pulse: column command issued
- done_write_out  out  1  write flag of the completed request, valid with done_out
- row_open_out  out  1  bank has an open row (state OPENING or ACTIVE)
- open_row_out  out  ROW_BITS  currently open row; 0 when closed

## Operation
- The request slot is a one-entry pending register holding {row, col, write, valid}.
- req_ready_out = !pending_valid. A request is accepted on an edge where req_valid_in && req_ready_out.
- States: CLOSED, OPENING, ACTIVE, CLOSING.
- CLOSED: if pending, present ACT with the pending row. On grant, set open_row to the pending row, load rcd = T_RCD-2 and ras = T_RAS-1, then go to OPENING.
- OPENING: no command. When rcd == 0, go to ACTIVE; otherwise decrement rcd.
- ACTIVE with a pending row hit: present RD or WR with the pending column once ccd == 0. On grant, clear pending, load ccd = T_CCD-1, and pulse done_out on the next cycle.
- ACTIVE with a pending row miss: present PRE once ras == 0. On grant, load rp = T_RP-2 and go to CLOSING.
- ACTIVE with no pending request: NOP. The row stays open.
- CLOSING: no command. When rp == 0, go to CLOSED and clear open_row; otherwise decrement rp. The pending request is retained, so ACT follows.
- Timers ras and ccd decrement every cycle and saturate at 0.
- cmd_* outputs are combinational from registered state, pending register and timers only. They do not depend on cmd_grant_in, so there is no combinational loop.
- cmd_grant_in while cmd_valid_out = 0 is ignored.
- A request accepted on the same edge as a column-command grant cannot occur, because ready is low while pending.

## Timing
- Reset (asynchronous): state CLOSED, pending cleared, all timers 0, open_row 0.
- Output values during reset: req_ready_out 1, cmd_valid_out 0, cmd_out 0, cmd_row_out 0, cmd_col_out 0, done_out 0, done_write_out 0, row_open_out 0, open_row_out 0.
- Reset mid-operation discards the pending request and open-row tracking. No completion is reported.
- Accept-to-command latency is 1 cycle: a request accepted at edge of cycle k gives a command presented in cycle k+1.
- If a command is granted in cycle N, the dependent command is presented no earlier than cycle N+T_x:
  - ACT to RD/WR: N+T_RCD.
  - PRE to ACT: N+T_RP.
  - ACT to PRE: N+T_RAS.
  - RD/WR to RD/WR: N+T_CCD.
- Commands are held with stable fields until granted; no timer is reloaded while waiting.
- done_out is asserted in cycle N+1 for a column grant in cycle N. req_ready_out rises in the same cycle.

## Test plan
All scenarios use default parameters with cmd_grant_in tied to 1, unless stated otherwise.
- Reset: assert rst_in asynchronously mid-cycle. All outputs take their reset values immediately; req_ready_out = 1.
- Closed-bank read: request row 0x12, col 0x5, read, accepted in cycle 0. ACT row 0x12 in cycle 1, RD col 0x5 in cycle 4, done_out = 1 with done_write_out = 0 in cycle 5, then row_open_out = 1 and open_row_out = 0x12.
- Row miss: after the previous scenario, request row 0x34 read accepted in cycle 5. PRE in cycle 9 (tRAS bound), ACT row 0x34 in cycle 12, RD in cycle 15, done in cycle 16.
- Row hit with T_CCD = 4: RD in cycle 4, then hit write col 0x6 accepted in cycle 5. WR col 0x6 appears in cycle 8; done_write_out = 1 in cycle 9.
- Grant stall: hold cmd_grant_in at 0 for 4 cycles while ACT is presented. cmd_valid_out, cmd_out and cmd_row_out stay constant and the state stays CLOSED; the ACT sequence proceeds from the first granted cycle.
- Reset in OPENING: pulse rst_in in cycle 2 of the closed-bank read. No RD is issued and done_out stays 0. A new request then starts again from ACT.

Source files
------------

// File: rtl/dram_bank_controller.sv
// dram_bank_controller: per-bank ACT/RD/WR/PRE sequencer with an open-row policy.
// Holds one pending request and issues the commands it needs while enforcing
// tRCD, tRP, tRAS and tCCD. Command outputs depend only on registered state,
// so the arbiter's grant can depend on them without forming a loop.
module dram_bank_controller #(
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 4,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3,
  parameter int T_RAS    = 8,
  parameter int T_CCD    = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic [ROW_BITS-1:0] req_row_in,
  input  logic [COL_BITS-1:0] req_col_in,
  input  logic                req_write_in,
  output logic                cmd_valid_out,
  output logic [2:0]          cmd_out,
  output logic [ROW_BITS-1:0] cmd_row_out,
  output logic [COL_BITS-1:0] cmd_col_out,
  input  logic                cmd_grant_in,
  output logic                done_out,
  output logic                done_write_out,
  output logic                row_open_out,
  output logic [ROW_BITS-1:0] open_row_out
);

  // Timer width: wide enough for the largest value ever loaded (T_x - 1).
  localparam int T_MAX_A = (T_RCD > T_RP)  ? T_RCD : T_RP;
  localparam int T_MAX_B = (T_RAS > T_CCD) ? T_RAS : T_CCD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_ACTIVE,
    ST_CLOSING
  } state_t;

  state_t                state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ROW_BITS-1:0]   pend_row_q, pend_row_d;
  logic [COL_BITS-1:0]   pend_col_q, pend_col_d;
  logic                  pend_write_q, pend_write_d;
  logic [ROW_BITS-1:0]   open_row_q, open_row_d;
  logic [TW-1:0]         rcd_q, rcd_d;
  logic [TW-1:0]         rp_q, rp_d;
  logic [TW-1:0]         ras_q, ras_d;
  logic [TW-1:0]         ccd_q, ccd_d;
  logic                  done_q, done_d;
  logic                  done_write_q, done_write_d;

  // State, pending slot, timers and completion flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_CLOSED;
      pend_valid_q <= 1'b0;
      pend_row_q   <= '0;
      pend_col_q   <= '0;
      pend_write_q <= 1'b0;
      open_row_q   <= '0;
      rcd_q        <= '0;
      rp_q         <= '0;
      ras_q        <= '0;
      ccd_q        <= '0;
      done_q       <= 1'b0;
      done_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_row_q   <= pend_row_d;
      pend_col_q   <= pend_col_d;
      pend_write_q <= pend_write_d;
      open_row_q   <= open_row_d;
      rcd_q        <= rcd_d;
      rp_q         <= rp_d;
      ras_q        <= ras_d;
      ccd_q        <= ccd_d;
      done_q       <= done_d;
      done_write_q <= done_write_d;
    end
  end

  // Next-state logic and the command presented to the arbiter.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_row_d    = pend_row_q;
    pend_col_d    = pend_col_q;
    pend_write_d  = pend_write_q;
    open_row_d    = open_row_q;
    rcd_d         = rcd_q;
    rp_d          = rp_q;
    ras_d         = (ras_q != '0) ? ras_q - TW'(1) : '0;
    ccd_d         = (ccd_q != '0) ? ccd_q - TW'(1) : '0;
    done_d        = 1'b0;
    done_write_d  = 1'b0;
    cmd_valid_out = 1'b0;
    cmd_out       = CMD_NOP;
    cmd_row_out   = '0;
    cmd_col_out   = '0;

    // The slot is empty whenever a request is accepted, so a column grant
    // (which needs a pending request) can never clash with this load.
    if (req_valid_in && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_row_d   = req_row_in;
      pend_col_d   = req_col_in;
      pend_write_d = req_write_in;
    end

    case (state_q)
      ST_CLOSED: begin
        if (pend_valid_q) begin
          cmd_valid_out = 1'b1;
          cmd_out       = CMD_ACT;
          cmd_row_out   = pend_row_q;
          if (cmd_grant_in) begin
            open_row_d = pend_row_q;
            rcd_d      = TW'(T_RCD - 2);
            ras_d      = TW'(T_RAS - 1);
            state_d    = ST_OPENING;
          end
        end
      end
      ST_OPENING: begin
        if (rcd_q == '0) state_d = ST_ACTIVE;
        else             rcd_d   = rcd_q - TW'(1);
      end
      ST_ACTIVE: begin
        if (pend_valid_q) begin
          if (pend_row_q == open_row_q) begin
            if (ccd_q == '0) begin
              cmd_valid_out = 1'b1;
              cmd_out       = pend_write_q ? CMD_WR : CMD_RD;
              cmd_col_out   = pend_col_q;
              if (cmd_grant_in) begin
                pend_valid_d = 1'b0;
                ccd_d        = TW'(T_CCD - 1);
                done_d       = 1'b1;
                done_write_d = pend_write_q;
              end
            end
          end else if (ras_q == '0) begin
            cmd_valid_out = 1'b1;
            cmd_out       = CMD_PRE;
            if (cmd_grant_in) begin
              rp_d    = TW'(T_RP - 2);
              state_d = ST_CLOSING;
            end
          end
        end
      end
      ST_CLOSING: begin
        // Pending request stays in the slot; ACT follows once closed.
        if (rp_q == '0) begin
          state_d    = ST_CLOSED;
          open_row_d = '0;
        end else begin
          rp_d = rp_q - TW'(1);
        end
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  assign req_ready_out  = !pend_valid_q;
  assign done_out       = done_q;
  assign done_write_out = done_write_q;
  assign row_open_out   = (state_q == ST_OPENING) || (state_q == ST_ACTIVE);
  assign open_row_out   = open_row_q;

endmodule
